// File: rtl/sig_store_monitor_pkg.sv
// Shared types and default addresses for the store monitor.
package sig_mon_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } sig_state_e;

   localparam logic [31:0] SIG_ADDR_DEF  = 32'h0000_0F00;
   localparam logic [31:0] HALT_ADDR_DEF = 32'hCAFE_BEEF;

endpackage

// File: rtl/sig_store_monitor_if.sv
// Store-traffic and signature-drain bus of the store monitor.
// master: core/host side, slave: the monitor.
interface sig_store_monitor_if #(
   parameter int DEPTH = 16
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic          st_en;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic          sig_valid;
   logic [31:0]   sig_data;
   logic          sig_ready;
   logic          halt;
   logic          overflow;
   logic [CW-1:0] count;

   modport master (
      output st_en, st_addr, st_data, sig_ready,
      input  sig_valid, sig_data, halt, overflow, count
   );

   modport slave (
      input  st_en, st_addr, st_data, sig_ready,
      output sig_valid, sig_data, halt, overflow, count
   );
endinterface

// File: rtl/sig_store_monitor_sync_fifo.sv
// First-word fall-through FIFO with a separate occupancy counter.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_wdata,
   output logic [W-1:0]               o_rdata,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata   = r_mem[r_rptr];
   assign o_count   = r_count;

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers wrap modulo DEPTH (power of two); count moves only on unpaired push/pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
      end
   end
endmodule

// File: rtl/sig_store_monitor.sv
// Store monitor: captures signature stores into a FIFO, drains them to the host,
// and runs the drain-then-halt end-of-test sequence on a halt store.
module sig_store_monitor
   import sig_mon_pkg::*;
#(
   parameter logic [31:0] SIG_ADDR  = SIG_ADDR_DEF,
   parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF,
   parameter int          DEPTH     = 16
) (
   input  logic               clk,
   input  logic               rst,
   sig_store_monitor_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] ST_RUN    = RUN;
   localparam logic [1:0] ST_DRAIN  = DRAIN;
   localparam logic [1:0] ST_HALTED = HALTED;

   logic [1:0]    r_state;
   logic          r_ovf;
   logic          w_sig_hit;
   logic          w_halt_hit;
   logic          w_push;
   logic          w_pop;
   logic          w_valid;
   logic          w_full;
   logic          w_empty;
   logic [31:0]   w_rdata;
   logic [CW-1:0] w_count;

   assign w_sig_hit  = bus.st_en && (bus.st_addr == SIG_ADDR);
   assign w_halt_hit = bus.st_en && (bus.st_addr == HALT_ADDR);
   assign w_push     = (r_state == ST_RUN) && w_sig_hit;
   assign w_valid    = (r_state != ST_HALTED) && !w_empty;
   assign w_pop      = w_valid && bus.sig_ready;

   sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (bus.st_data),
      .o_rdata (w_rdata),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // RUN -> DRAIN on a halt store; DRAIN -> HALTED once the FIFO is seen empty.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:   if (w_halt_hit)       r_state <= ST_DRAIN;
            ST_DRAIN: if (w_count == '0)    r_state <= ST_HALTED;
            default:                        r_state <= ST_HALTED;
         endcase
      end
   end

   // Sticky drop flag: a signature push that found no free slot.
   always_ff @(posedge clk) begin
      if (!rst)                           r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
   end

   assign bus.sig_valid = w_valid;
   assign bus.sig_data  = w_rdata;
   assign bus.halt      = (r_state == ST_HALTED);
   assign bus.overflow  = r_ovf;
   assign bus.count     = w_count;
endmodule

// File: tb/tb_sig_store_monitor.sv
// Directed + randomized bench for sig_store_monitor against a queue-based model.
module tb_sig_store_monitor;
   import sig_mon_pkg::*;

   localparam int          DEPTH = 16;
   localparam logic [31:0] SA    = 32'h0000_0F00;
   localparam logic [31:0] HA    = 32'hCAFE_BEEF;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sig_store_monitor_if #(.DEPTH(DEPTH)) bus ();

   sig_store_monitor #(.SIG_ADDR(SA), .HALT_ADDR(HA), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: 0=run 1=drain 2=halted
   logic [31:0] mq[$];
   int          mst  = 0;
   bit          movf = 0;
   logic [31:0] got[$];
   int          cyc = 0;
   int          last_pop_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit en, input logic [31:0] addr, input logic [31:0] data,
                             input bit ready, input bit r);
      bit v, p, full, psh;
      if (!r) begin
         mq.delete(); mst = 0; movf = 0;
         return;
      end
      v    = (mst != 2) && (mq.size() != 0);
      p    = v && ready;
      full = (mq.size() == DEPTH);
      psh  = 0;
      if (mst == 0) begin
         if (en && addr == SA) begin
            if (!full || p) psh = 1;
            else movf = 1;
         end
         if (en && addr == HA) mst = 1;
      end else if (mst == 1) begin
         if (mq.size() == 0) mst = 2;
      end
      if (p) void'(mq.pop_front());
      if (psh) mq.push_back(data);
   endtask

   task automatic check_all(input string tag);
      bit ev;
      ev = (mst != 2) && (mq.size() != 0);
      chk({tag, "_count"}, 32'(bus.count), 32'(mq.size()));
      chk({tag, "_valid"}, 32'(bus.sig_valid), 32'(ev));
      chk({tag, "_halt"}, 32'(bus.halt), 32'(mst == 2));
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(movf));
      if (ev) chk({tag, "_data"}, bus.sig_data, mq[0]);
   endtask

   task automatic step(input bit en, input logic [31:0] addr, input logic [31:0] data,
                       input bit ready, input string tag);
      bus.st_en     = en;
      bus.st_addr   = addr;
      bus.st_data   = data;
      bus.sig_ready = ready;
      #0;
      if (rst && bus.sig_valid && ready) begin
         got.push_back(bus.sig_data);
         last_pop_cyc = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      model_edge(en, addr, data, ready, rst);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(0, 0, 0, 0, "rst");
      rst = 1'b1;
      got.delete();
   endtask

   initial begin
      int halt_cyc;
      logic [31:0] sent[$];
      bus.st_en = 0; bus.st_addr = 0; bus.st_data = 0; bus.sig_ready = 0;

      // Reset state
      rst = 1'b0;
      step(0, 0, 0, 1, "rst0");
      step(0, 0, 0, 1, "rst1");
      chk("reset_count", 32'(bus.count), 0);
      chk("reset_valid", 32'(bus.sig_valid), 0);
      chk("reset_halt", 32'(bus.halt), 0);
      chk("reset_ovf", 32'(bus.overflow), 0);
      rst = 1'b1;

      // Basic capture
      got.delete();
      step(1, SA, 32'h11, 1, "basic");
      step(1, SA, 32'h22, 1, "basic");
      step(1, SA, 32'h33, 1, "basic");
      step(0, 0, 0, 1, "basic");
      step(0, 0, 0, 1, "basic");
      chk("basic_n", 32'(got.size()), 3);
      if (got.size() == 3) begin
         chk("basic_w0", got[0], 32'h11);
         chk("basic_w1", got[1], 32'h22);
         chk("basic_w2", got[2], 32'h33);
      end
      chk("basic_ovf", 32'(bus.overflow), 0);

      // Backpressure and halt
      do_reset();
      for (int i = 0; i < 5; i++) step(1, SA, 32'hA0 + 32'(i), 0, "bp");
      step(1, HA, 0, 0, "bp_halt");
      step(1, SA, 32'hDEAD, 0, "bp_drain_st");
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, "bp_wait");
      halt_cyc = -1;
      for (int i = 0; i < 20 && halt_cyc < 0; i++) begin
         step(0, 0, 0, 1, "bp_drain");
         if (bus.halt) halt_cyc = cyc;
      end
      chk("bp_halted", 32'(halt_cyc >= 0), 1);
      chk("bp_n", 32'(got.size()), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("bp_word", got[i], 32'hA0 + 32'(i));
      chk("bp_halt_lag", 32'(halt_cyc - last_pop_cyc), 1);

      // Overflow and wrap
      do_reset();
      for (int i = 1; i <= 17; i++) step(1, SA, 32'(i), 0, "ovf");
      chk("ovf_count", 32'(bus.count), 16);
      chk("ovf_flag", 32'(bus.overflow), 1);
      for (int i = 0; i < 17; i++) step(0, 0, 0, 1, "ovf_drain");
      chk("ovf_n", 32'(got.size()), 16);
      for (int i = 0; i < 16 && i < got.size(); i++) chk("ovf_word", got[i], 32'(i + 1));
      got.delete();
      for (int i = 0; i < 40; i++) begin
         sent.push_back($urandom);
         step(1, SA, sent[i], 1, "wrap");
      end
      step(0, 0, 0, 1, "wrap");
      step(0, 0, 0, 1, "wrap");
      chk("wrap_n", 32'(got.size()), 40);
      for (int i = 0; i < 40 && i < got.size(); i++) chk("wrap_word", got[i], sent[i]);

      // Full with simultaneous push/pop
      do_reset();
      for (int i = 0; i < 16; i++) step(1, SA, 32'd100 + 32'(i), 0, "full");
      step(1, SA, 32'h777, 1, "full_pp");
      chk("full_pp_count", 32'(bus.count), 16);
      chk("full_pp_ovf", 32'(bus.overflow), 0);
      for (int i = 0; i < 17; i++) step(0, 0, 0, 1, "full_drain");
      chk("full_n", 32'(got.size()), 17);
      if (got.size() == 17) chk("full_last", got[16], 32'h777);

      // Halt on empty FIFO
      do_reset();
      step(1, HA, 0, 1, "he");
      chk("he_halt_n1", 32'(bus.halt), 0);
      step(0, 0, 0, 1, "he");
      chk("he_halt_n2", 32'(bus.halt), 1);
      for (int i = 0; i < 3; i++) step(1, SA, 32'd5, 1, "he_st");
      chk("he_valid", 32'(bus.sig_valid), 0);

      // Reset mid-DRAIN
      do_reset();
      for (int i = 0; i < 3; i++) step(1, SA, 32'hB0 + 32'(i), 0, "rm");
      step(1, HA, 0, 0, "rm_halt");
      step(0, 0, 0, 0, "rm_drain");
      rst = 1'b0;
      step(0, 0, 0, 0, "rm_rst");
      rst = 1'b1;
      chk("rm_count", 32'(bus.count), 0);
      chk("rm_halt", 32'(bus.halt), 0);
      chk("rm_ovf", 32'(bus.overflow), 0);
      step(1, SA, 32'h55, 0, "rm_new");
      chk("rm_new_valid", 32'(bus.sig_valid), 1);
      chk("rm_new_data", bus.sig_data, 32'h55);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         int sel;
         logic [31:0] a;
         sel = $urandom_range(0, 31);
         a = (sel < 20) ? SA : (sel == 20) ? HA : $urandom;
         rst = !(mst == 2 && $urandom_range(0, 3) == 0);
         step($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 2) != 0, "rnd");
         rst = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sig_store_monitor.md
# sig_store_monitor

Synthesizable store monitor that sits directly downstream of the pipeline's memory/write-back stage and consumes committed data-memory store traffic. Stores to the signature address are captured into a FIFO and drained to a host-side consumer over a valid/ready port. A store to the halt address triggers a drain-then-halt sequence. This makes the compliance-signature and end-of-test protocol available in hardware (FPGA or emulation), not only in simulation.

## Interface
- `SIG_ADDR`, default 32'h0000_0F00: store address whose data is captured as a signature word.
- `HALT_ADDR`, default 32'hCAFE_BEEF: store address that requests end of test.
- `DEPTH`, default 16: FIFO entries; power of two, minimum 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `st_en` in 1: a store commits this cycle, active-high. The core's Dmem write strobe is active-low and is inverted at instantiation.
- `st_addr` in 32: committed store address (the write-back-stage ALU result).
- `st_data` in 32: committed store data.
- `sig_valid` out 1: `sig_data` holds a valid signature word.
- `sig_data` out 32: head-of-FIFO word.
- `sig_ready` in 1: consumer accepts the word.
- `halt` out 1: test finished and all signature words delivered; sticky.
- `overflow` out 1: at least one signature word was dropped; sticky.
- `count` out $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- States: RUN, DRAIN, HALTED.
- **RUN, signature store:** `st_en` with `st_addr==SIG_ADDR` pushes `st_data`.
- **RUN, halt store:** `st_en` with `st_addr==HALT_ADDR` moves to DRAIN.
- **RUN, other stores:** ignored. Address compare is exact 32-bit; no masking.
- **DRAIN:** all stores are ignored and the FIFO keeps draining. Move to HALTED on the first edge where `count==0` at the start of the cycle.
- **HALTED:** `halt=1`, all stores ignored, `sig_valid=0`. Only reset leaves HALTED.
- **Pop:** occurs when `sig_valid && sig_ready`. `sig_valid = (count!=0)` in RUN and DRAIN.
- **Full FIFO:**
  - push with pop in the same cycle: both occur, `count` unchanged.
  - push without pop: word dropped, `overflow` set, `count` unchanged.
- **Empty FIFO:** `sig_ready` has no effect and `count` stays 0.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, so full and empty are unambiguous.
- **Reset values (`rst==0` at an edge):** state RUN; pointers 0; `count` 0; `sig_valid` 0; `halt` 0; `overflow` 0; `sig_data` don't-care (bench must not check it). Reset mid-DRAIN or in HALTED discards all FIFO content.

## Timing
- **Push latency:** a push at edge N makes the word visible on `sig_data`, with `sig_valid=1`, after edge N when the FIFO was empty (first-word fall-through).
- **Pop:** a pop at edge N presents the next entry after edge N. With `sig_ready` held high, one word is delivered per cycle.
- **Halt, FIFO empty:** halt store at edge N enters DRAIN; the DRAIN-to-HALTED transition happens at edge N+1; `halt` is high after N+1.
- **Halt, FIFO non-empty:** `halt` rises one edge after the final pop empties the FIFO.
- **`sig_data` stability:** must not change while `sig_valid && !sig_ready`.

## Structure
- Package `sig_mon_pkg` holds:
  - the state enum `sig_state_e` (RUN, DRAIN, HALTED);
  - default address constants `SIG_ADDR_DEF` and `HALT_ADDR_DEF`.
- Sub-module `sync_fifo`, parameterized by width and depth:
  - interface: push, pop, `wdata`, `rdata`, `count`, `full`, `empty`;
  - implements the push/pop/wrap rules above.
- The top level holds the address decode, the state machine and the sticky flags.

## Test plan
- **Basic capture:** reset, then stores to 0xF00 of 0x11, 0x22, 0x33 with `sig_ready=1` → words 0x11, 0x22, 0x33 delivered in order, one per cycle; `overflow=0`.
- **Backpressure and halt:** `sig_ready=0`, 5 signature stores, then a store to 0xCAFEBEEF; raise `sig_ready` 10 cycles later → all 5 words delivered. `halt` rises exactly one edge after the 5th pop. A signature store issued during DRAIN is not delivered.
- **Overflow and wrap:** DEPTH=16, `sig_ready=0`, 17 stores of 1..17 → `count=16`, `overflow=1`, drain yields 1..16. Repeat 40 push/pop pairs to cross pointer wrap → data order preserved.
- **Full with simultaneous push/pop:** full FIFO, `sig_ready=1` and a push in the same cycle → `count` stays 16, no overflow, new word appears last.
- **Halt on empty FIFO:** halt store with FIFO empty → `halt=1` two edges later. Subsequent stores to 0xF00 → `sig_valid` stays 0.
- **Reset mid-operation:** assert `rst=0` for one edge during DRAIN with 3 words queued → `count=0`, `halt=0`, `overflow=0`, state RUN; a new store to 0xF00 is captured normally.
